// File: rtl/mat_axis_tx.sv
// AXI4-Stream frame serializer for the matrix accumulator input.
// An active plus shadow frame buffer lets consecutive frames stream with no idle beat.
module mat_axis_tx #(
    parameter int DATA_W   = 8,
    parameter int N        = 2,
    parameter int NUM_MATS = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_load,
    input  logic [DATA_W*NUM_MATS*N*N-1:0]     i_load_data,
    output logic                               o_load_ready,
    output logic [DATA_W-1:0]                  m_axis_data,
    output logic                               m_axis_valid,
    input  logic                               m_axis_ready,
    output logic                               m_axis_last,
    output logic [15:0]                        o_frames_sent
);

    localparam int L       = NUM_MATS * N * N;
    localparam int IDX_W   = (L > 1) ? $clog2(L) : 1;
    localparam int FRAME_W = DATA_W * L;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(L - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_SEND_PEND = 2'd2
    } state_e;

    logic [FRAME_W-1:0] active_r;
    logic [FRAME_W-1:0] shadow_r;
    logic [IDX_W-1:0]   idx_r;
    logic               active_full_r;
    logic               shadow_full_r;
    logic [15:0]        frames_r;
    logic               valid_r;
    logic               last_r;
    logic [DATA_W-1:0]  data_r;
    logic               load_ready_r;

    logic [FRAME_W-1:0] next_active_s;
    logic [FRAME_W-1:0] next_shadow_s;
    logic [IDX_W-1:0]   next_idx_s;
    logic               next_active_full_s;
    logic               next_shadow_full_s;
    logic [15:0]        next_frames_s;
    logic               load_acc_s;
    logic               hs_s;
    logic               last_hs_s;
    state_e             state_s;

    function automatic logic [DATA_W-1:0] elem_f(input logic [FRAME_W-1:0] frame,
                                                 input logic [IDX_W-1:0]   idx);
        return frame[int'(idx)*DATA_W +: DATA_W];
    endfunction

    assign load_acc_s = i_load & ~shadow_full_r;
    assign hs_s       = active_full_r & m_axis_ready;
    assign last_hs_s  = hs_s & (idx_r == IDX_LAST);

    // Operating mode decoded from the two buffer-occupancy flags
    always_comb begin
        state_s = ST_IDLE;
        if (!active_full_r) begin
            state_s = ST_IDLE;
        end else if (!shadow_full_r) begin
            state_s = ST_SEND;
        end else begin
            state_s = ST_SEND_PEND;
        end
    end

    // Next-state logic for buffers, element index and occupancy flags
    always_comb begin
        next_active_s      = active_r;
        next_shadow_s      = shadow_r;
        next_idx_s         = idx_r;
        next_active_full_s = active_full_r;
        next_shadow_full_s = shadow_full_r;
        case (state_s)
            ST_IDLE: begin
                if (load_acc_s) begin
                    next_active_s      = i_load_data;
                    next_idx_s         = IDX_ZERO;
                    next_active_full_s = 1'b1;
                end else begin
                    next_active_full_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    next_idx_s = IDX_ZERO;
                    // A load landing on the last beat goes straight into active
                    if (load_acc_s) begin
                        next_active_s      = i_load_data;
                        next_active_full_s = 1'b1;
                    end else begin
                        next_active_full_s = 1'b0;
                    end
                end else begin
                    if (hs_s) begin
                        next_idx_s = idx_r + IDX_ONE;
                    end else begin
                        next_idx_s = idx_r;
                    end
                    if (load_acc_s) begin
                        next_shadow_s      = i_load_data;
                        next_shadow_full_s = 1'b1;
                    end else begin
                        next_shadow_full_s = 1'b0;
                    end
                end
            end
            ST_SEND_PEND: begin
                if (last_hs_s) begin
                    next_active_s      = shadow_r;
                    next_idx_s         = IDX_ZERO;
                    next_shadow_full_s = 1'b0;
                end else if (hs_s) begin
                    next_idx_s = idx_r + IDX_ONE;
                end else begin
                    next_idx_s = idx_r;
                end
            end
            default: begin
                next_idx_s         = IDX_ZERO;
                next_active_full_s = 1'b0;
                next_shadow_full_s = 1'b0;
            end
        endcase
    end

    // Completed-frame counter, wrapping naturally at 16 bits
    always_comb begin
        if (last_hs_s) begin
            next_frames_s = frames_r + 16'd1;
        end else begin
            next_frames_s = frames_r;
        end
    end

    // State registers; outputs are registered from the next-state values
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            active_r      <= {FRAME_W{1'b0}};
            shadow_r      <= {FRAME_W{1'b0}};
            idx_r         <= IDX_ZERO;
            active_full_r <= 1'b0;
            shadow_full_r <= 1'b0;
            frames_r      <= 16'd0;
            valid_r       <= 1'b0;
            last_r        <= 1'b0;
            data_r        <= {DATA_W{1'b0}};
            load_ready_r  <= 1'b1;
        end else begin
            active_r      <= next_active_s;
            shadow_r      <= next_shadow_s;
            idx_r         <= next_idx_s;
            active_full_r <= next_active_full_s;
            shadow_full_r <= next_shadow_full_s;
            frames_r      <= next_frames_s;
            valid_r       <= next_active_full_s;
            last_r        <= next_active_full_s & (next_idx_s == IDX_LAST);
            data_r        <= next_active_full_s ? elem_f(next_active_s, next_idx_s)
                                                : {DATA_W{1'b0}};
            load_ready_r  <= ~next_shadow_full_s;
        end
    end

    assign o_load_ready  = load_ready_r;
    assign m_axis_valid  = valid_r;
    assign m_axis_last   = last_r;
    assign m_axis_data   = data_r;
    assign o_frames_sent = frames_r;

endmodule

// File: tb/tb_mat_axis_tx.sv
// Directed self-checking bench for mat_axis_tx with default parameters (L = 8).
module tb_mat_axis_tx;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_load;
    logic [63:0] i_load_data;
    logic        o_load_ready;
    logic [7:0]  m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic        m_axis_last;
    logic [15:0] o_frames_sent;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] frame_a = 64'h8070605040302010;
    logic [63:0] frame_b = 64'h0807060504030201;
    logic [63:0] frame_c = 64'hEEEEEEEEEEEEEEEE;

    mat_axis_tx dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_load        (i_load),
        .i_load_data   (i_load_data),
        .o_load_ready  (o_load_ready),
        .m_axis_data   (m_axis_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_last   (m_axis_last),
        .o_frames_sent (o_frames_sent)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Check the beat on display at this negedge, let it handshake, drop any load request.
    task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, m_axis_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, m_axis_data}, {24'd0, d});
        chk({tag, "_last"}, {31'd0, m_axis_last}, {31'd0, l});
        @(posedge i_clk);
        #1 i_load = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic run_frame(input string tag, input logic [63:0] f);
        i_load      = 1'b1;
        i_load_data = f;
        @(posedge i_clk);
        #1 i_load = 1'b0;
        @(negedge i_clk);
        for (int k = 0; k < 8; k++) expect_beat(tag, f[k*8 +: 8], k == 7);
        chk({tag, "_idle"}, {31'd0, m_axis_valid}, 32'd0);
    endtask

    initial begin
        int exp_i;
        i_rst        = 1'b1;
        i_load       = 1'b0;
        i_load_data  = 64'd0;
        m_axis_ready = 1'b1;

        // Reset state
        @(negedge i_clk);
        chk("rst_valid", {31'd0, m_axis_valid}, 32'd0);
        chk("rst_last", {31'd0, m_axis_last}, 32'd0);
        chk("rst_data", {24'd0, m_axis_data}, 32'd0);
        chk("rst_ready", {31'd0, o_load_ready}, 32'd1);
        chk("rst_frames", {16'd0, o_frames_sent}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_valid", {31'd0, m_axis_valid}, 32'd0);

        // Single frame
        run_frame("single", frame_a);
        chk("single_frames", {16'd0, o_frames_sent}, 32'd1);
        chk("single_ldrdy", {31'd0, o_load_ready}, 32'd1);

        // Back-to-back frames; data changes after capture must not matter
        i_load      = 1'b1;
        i_load_data = frame_a;
        @(posedge i_clk);
        #1 i_load_data = frame_b;
        @(negedge i_clk);
        expect_beat("b2b_a0", 8'h10, 1'b0);
        i_load_data = 64'hFFFFFFFFFFFFFFFF;
        for (int k = 1; k < 8; k++) begin
            chk("b2b_ldrdy_low", {31'd0, o_load_ready}, 32'd0);
            expect_beat("b2b_a", frame_a[k*8 +: 8], k == 7);
        end
        chk("b2b_ldrdy_high", {31'd0, o_load_ready}, 32'd1);
        for (int k = 0; k < 8; k++) expect_beat("b2b_b", frame_b[k*8 +: 8], k == 7);
        chk("b2b_idle", {31'd0, m_axis_valid}, 32'd0);
        chk("b2b_frames", {16'd0, o_frames_sent}, 32'd3);

        // Load in the same cycle as the last beat
        i_load      = 1'b1;
        i_load_data = frame_a;
        @(posedge i_clk);
        #1 i_load = 1'b0;
        @(negedge i_clk);
        for (int k = 0; k < 7; k++) expect_beat("lb_a", frame_a[k*8 +: 8], 1'b0);
        i_load      = 1'b1;
        i_load_data = frame_b;
        chk("lb_ldrdy", {31'd0, o_load_ready}, 32'd1);
        expect_beat("lb_a7", 8'h80, 1'b1);
        for (int k = 0; k < 8; k++) expect_beat("lb_b", frame_b[k*8 +: 8], k == 7);
        chk("lb_frames", {16'd0, o_frames_sent}, 32'd5);

        // Third load while shadow is full is ignored
        i_load      = 1'b1;
        i_load_data = frame_a;
        @(posedge i_clk);
        #1 i_load_data = frame_b;
        @(negedge i_clk);
        expect_beat("ref_a0", 8'h10, 1'b0);
        i_load      = 1'b1;
        i_load_data = frame_c;
        chk("ref_ldrdy", {31'd0, o_load_ready}, 32'd0);
        for (int k = 1; k < 8; k++) expect_beat("ref_a", frame_a[k*8 +: 8], k == 7);
        for (int k = 0; k < 8; k++) expect_beat("ref_b", frame_b[k*8 +: 8], k == 7);
        chk("ref_idle", {31'd0, m_axis_valid}, 32'd0);
        chk("ref_frames", {16'd0, o_frames_sent}, 32'd7);

        // Random backpressure: order must be exact, no drops or duplicates
        m_axis_ready = 1'b0;
        i_load       = 1'b1;
        i_load_data  = frame_a;
        @(posedge i_clk);
        #1 i_load = 1'b0;
        @(negedge i_clk);
        exp_i = 0;
        for (int cyc = 0; cyc < 200 && exp_i < 8; cyc++) begin
            chk("bp_valid", {31'd0, m_axis_valid}, 32'd1);
            chk("bp_data", {24'd0, m_axis_data}, {24'd0, frame_a[exp_i*8 +: 8]});
            chk("bp_last", {31'd0, m_axis_last}, (exp_i == 7) ? 32'd1 : 32'd0);
            m_axis_ready = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            if (m_axis_ready) exp_i++;
            @(negedge i_clk);
        end
        chk("bp_done", exp_i, 32'd8);
        m_axis_ready = 1'b1;
        chk("bp_idle", {31'd0, m_axis_valid}, 32'd0);
        chk("bp_frames", {16'd0, o_frames_sent}, 32'd8);

        // Asynchronous reset mid-frame
        i_load      = 1'b1;
        i_load_data = frame_a;
        @(posedge i_clk);
        #1 i_load = 1'b0;
        @(negedge i_clk);
        for (int k = 0; k < 3; k++) expect_beat("mr_a", frame_a[k*8 +: 8], 1'b0);
        i_rst = 1'b1;
        #1;
        chk("mr_valid", {31'd0, m_axis_valid}, 32'd0);
        chk("mr_last", {31'd0, m_axis_last}, 32'd0);
        chk("mr_data", {24'd0, m_axis_data}, 32'd0);
        chk("mr_ldrdy", {31'd0, o_load_ready}, 32'd1);
        chk("mr_frames", {16'd0, o_frames_sent}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mr_no_resume", {31'd0, m_axis_valid}, 32'd0);
        run_frame("mr_b", frame_b);
        chk("mr_frames_after", {16'd0, o_frames_sent}, 32'd1);

        // Counter wrap
        force dut.frames_r = 16'hFFFE;
        #1;
        release dut.frames_r;
        @(negedge i_clk);
        chk("wrap_preset", {16'd0, o_frames_sent}, 32'h0000FFFE);
        run_frame("wrap_a", frame_a);
        chk("wrap_ffff", {16'd0, o_frames_sent}, 32'h0000FFFF);
        run_frame("wrap_b", frame_b);
        chk("wrap_zero", {16'd0, o_frames_sent}, 32'h00000000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
